// File: rtl/digital_analog_control.sv
// -----------------------------------------------------------------------------
// digital_analog_control
//   Emulates analog cabinet controls (steering wheel, pedal, paddle) from
//   digital Plus/Minus buttons. Each channel is stepped at most once per video
//   frame, on the rising edge of Vsync. A channel either springs back to
//   VCENTER when released or holds its last position. Holding a button
//   doubles the step size every ACCEL_FRAMES frames, up to STEP_MAX.
//
// Ports
//   Clk       core clock
//   Rst_n     asynchronous active-low reset
//   Vsync     vsync level, Clk-synchronous; its rising edge is the frame tick
//   Plus      per-channel increase button (level)
//   Minus     per-channel decrease button (level)
//   Recenter  synchronous reload of all channels to their rest values
//   Value     packed channel values, channel i at [i*W +: W]
//   Update    one-cycle pulse after a frame tick or a Recenter
//   Active    channel i is ramping or returning to centre
// -----------------------------------------------------------------------------
module digital_analog_control #(
  parameter int unsigned    NCH          = 2,
  parameter int unsigned    W            = 8,
  parameter logic [W-1:0]   VMIN         = 8'h00,
  parameter logic [W-1:0]   VMAX         = 8'hFF,
  parameter logic [W-1:0]   VCENTER      = 8'h80,
  parameter logic [NCH-1:0] CENTER_MASK  = 2'b01,
  parameter int unsigned    STEP_INIT    = 1,
  parameter int unsigned    STEP_MAX     = 8,
  parameter int unsigned    ACCEL_FRAMES = 4,
  parameter int unsigned    RETURN_STEP  = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Vsync,
  input  logic [NCH-1:0]     Plus,
  input  logic [NCH-1:0]     Minus,
  input  logic               Recenter,
  output logic [NCH*W-1:0]   Value,
  output logic               Update,
  output logic [NCH-1:0]     Active
);

  localparam int unsigned  HW    = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES + 1) : 1;
  localparam logic [W-1:0]  SINIT = W'(STEP_INIT);
  localparam logic [W-1:0]  SMAX  = W'(STEP_MAX);
  localparam logic [W-1:0]  RSTEP = W'(RETURN_STEP);
  localparam logic [HW-1:0] ACC   = HW'(ACCEL_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_RETURN = 2'd2
  } state_t;

  logic                      vs_d_p1;
  logic                      vld_p1;
  logic [NCH-1:0][W-1:0]     val_p1,  val_nx;
  logic [NCH-1:0][W-1:0]     step_p1, step_nx;
  logic [NCH-1:0][HW-1:0]    hold_p1, hold_nx;
  logic [NCH-1:0]            dir_p1,  dir_nx;   // 1 = increasing
  state_t [NCH-1:0]          st_p1,   st_nx;
  logic                      tick;
  logic [NCH-1:0]            pressed;

  function automatic logic [W-1:0] rest_val(input int ch);
    return CENTER_MASK[ch] ? VCENTER : VMIN;
  endfunction

  // Move v by s in the given direction, saturating at [VMIN, VMAX].
  // One extra bit of headroom keeps the overflow test exact.
  function automatic logic [W-1:0] apply_step(input logic [W-1:0] v,
                                               input logic [W-1:0] s,
                                               input logic         up);
    logic [W:0] acc;
    if (up) begin
      acc = {1'b0, v} + {1'b0, s};
      if (acc > {1'b0, VMAX}) return VMAX;
      return acc[W-1:0];
    end
    acc = {1'b0, VMIN} + {1'b0, s};
    if ({1'b0, v} < acc) return VMIN;
    return v - s;
  endfunction

  // One spring-return step; lands exactly on VCENTER instead of overshooting.
  function automatic logic [W-1:0] toward_center(input logic [W-1:0] v);
    logic [W-1:0] diff;
    if (v > VCENTER) begin
      diff = v - VCENTER;
      return (diff <= RSTEP) ? VCENTER : v - RSTEP;
    end
    diff = VCENTER - v;
    return (diff <= RSTEP) ? VCENTER : v + RSTEP;
  endfunction

  function automatic logic [W-1:0] double_step(input logic [W-1:0] s);
    logic [W:0] dbl;
    dbl = {s, 1'b0};
    return (dbl > {1'b0, SMAX}) ? SMAX : dbl[W-1:0];
  endfunction

  assign tick    = Vsync & ~vs_d_p1;
  assign pressed = Plus ^ Minus;   // both or neither pressed means no direction

  always_comb begin
    val_nx  = val_p1;
    step_nx = step_p1;
    hold_nx = hold_p1;
    dir_nx  = dir_p1;
    st_nx   = st_p1;
    for (int i = 0; i < NCH; i++) begin
      if (Recenter) begin
        // Recenter wins over a coincident tick
        val_nx[i]  = rest_val(i);
        st_nx[i]   = ST_IDLE;
        step_nx[i] = SINIT;
        hold_nx[i] = '0;
      end else if (tick) begin
        case (st_p1[i])
          ST_RAMP: begin
            if (pressed[i] && (Plus[i] == dir_p1[i])) begin
              if ((hold_p1[i] + HW'(1)) == ACC) begin
                step_nx[i] = double_step(step_p1[i]);
                hold_nx[i] = '0;
                val_nx[i]  = apply_step(val_p1[i], double_step(step_p1[i]), dir_p1[i]);
              end else begin
                hold_nx[i] = hold_p1[i] + HW'(1);
                val_nx[i]  = apply_step(val_p1[i], step_p1[i], dir_p1[i]);
              end
            end else if (pressed[i]) begin
              step_nx[i] = SINIT;
              hold_nx[i] = '0;
              dir_nx[i]  = Plus[i];
              val_nx[i]  = apply_step(val_p1[i], SINIT, Plus[i]);
            end else begin
              // Released: no movement on this frame
              step_nx[i] = SINIT;
              hold_nx[i] = '0;
              st_nx[i]   = (CENTER_MASK[i] && (val_p1[i] != VCENTER)) ? ST_RETURN : ST_IDLE;
            end
          end
          default: begin
            // ST_IDLE and ST_RETURN both start a fresh ramp on a press
            if (pressed[i]) begin
              st_nx[i]   = ST_RAMP;
              step_nx[i] = SINIT;
              hold_nx[i] = '0;
              dir_nx[i]  = Plus[i];
              val_nx[i]  = apply_step(val_p1[i], SINIT, Plus[i]);
            end else if (st_p1[i] == ST_RETURN) begin
              val_nx[i] = toward_center(val_p1[i]);
              if (toward_center(val_p1[i]) == VCENTER) st_nx[i] = ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  // ---- stage p1: channel state, values and update pulse ----
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vs_d_p1 <= 1'b0;
      vld_p1  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        val_p1[i]  <= rest_val(i);
        step_p1[i] <= SINIT;
        hold_p1[i] <= '0;
        dir_p1[i]  <= 1'b0;
        st_p1[i]   <= ST_IDLE;
      end
    end else begin
      vs_d_p1 <= Vsync;
      vld_p1  <= tick | Recenter;
      val_p1  <= val_nx;
      step_p1 <= step_nx;
      hold_p1 <= hold_nx;
      dir_p1  <= dir_nx;
      st_p1   <= st_nx;
    end
  end

  always_comb begin
    Active = '0;
    for (int i = 0; i < NCH; i++) Active[i] = (st_p1[i] != ST_IDLE);
  end

  assign Value  = val_p1;
  assign Update = vld_p1;

endmodule

// File: tb/tb_digital_analog_control.sv
// -----------------------------------------------------------------------------
// tb_digital_analog_control
//   Drives frames of button activity into digital_analog_control and checks
//   every cycle against an integer model of the control's frame behaviour,
//   plus hand-computed values for the key scenarios.
// -----------------------------------------------------------------------------
module tb_digital_analog_control;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Vsync = 1'b0;
  logic [1:0]  Plus = 2'b00;
  logic [1:0]  Minus = 2'b00;
  logic        Recenter = 1'b0;
  logic [15:0] Value;
  logic        Update;
  logic [1:0]  Active;

  digital_analog_control dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Vsync    (Vsync),
    .Plus     (Plus),
    .Minus    (Minus),
    .Recenter (Recenter),
    .Value    (Value),
    .Update   (Update),
    .Active   (Active)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 = at rest, 1 = button held, 2 = springing back
  localparam bit [1:0] CMASK = 2'b01;
  int m_val[2], m_step[2], m_hold[2], m_mode[2], m_dir[2];
  bit m_vsd, m_upd, m_tk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampv(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  task automatic m_rest();
    for (int i = 0; i < 2; i++) begin
      m_val[i]  = CMASK[i] ? 128 : 0;
      m_step[i] = 1;
      m_hold[i] = 0;
      m_mode[i] = 0;
      m_dir[i]  = 0;
    end
  endtask

  task automatic m_frame(input int i, input int d);
    if (m_mode[i] == 1) begin
      if (d != 0 && d == m_dir[i]) begin
        m_hold[i]++;
        if (m_hold[i] == 4) begin
          m_step[i] = (m_step[i] * 2 > 8) ? 8 : m_step[i] * 2;
          m_hold[i] = 0;
        end
        m_val[i] = clampv(m_val[i] + d * m_step[i]);
      end else if (d != 0) begin
        m_step[i] = 1; m_hold[i] = 0; m_dir[i] = d;
        m_val[i] = clampv(m_val[i] + d);
      end else begin
        m_step[i] = 1; m_hold[i] = 0;
        m_mode[i] = (CMASK[i] && m_val[i] != 128) ? 2 : 0;
      end
    end else if (d != 0) begin
      m_mode[i] = 1; m_step[i] = 1; m_hold[i] = 0; m_dir[i] = d;
      m_val[i] = clampv(m_val[i] + d);
    end else if (m_mode[i] == 2) begin
      if (m_val[i] - 128 <= 4 && 128 - m_val[i] <= 4) begin
        m_val[i] = 128; m_mode[i] = 0;
      end else begin
        m_val[i] = m_val[i] + ((m_val[i] > 128) ? -4 : 4);
      end
    end
  endtask

  initial begin
    m_rest();
    m_vsd = 1'b0;
    m_upd = 1'b0;
    forever begin
      @(posedge Clk or negedge Rst_n);
      if (!Rst_n) begin
        m_rest();
        m_vsd = 1'b0;
        m_upd = 1'b0;
      end else begin
        m_tk  = Vsync && !m_vsd;
        m_vsd = Vsync;
        m_upd = m_tk || Recenter;
        if (Recenter) m_rest();
        else if (m_tk)
          for (int i = 0; i < 2; i++) m_frame(i, int'(Plus[i]) - int'(Minus[i]));
      end
    end
  end

  initial begin
    logic [15:0] ev;
    forever begin
      @(negedge Clk);
      if (chk_en) begin
        ev = {8'(m_val[1]), 8'(m_val[0])};
        chk("value", int'(Value), int'(ev));
        chk("update", int'(Update), int'(m_upd));
        chk("active0", int'(Active[0]), int'(m_mode[0] != 0));
        chk("active1", int'(Active[1]), int'(m_mode[1] != 0));
      end
    end
  end

  // rec: 0 none, 1 Recenter on the tick cycle, 2 Recenter mid-frame
  task automatic frame(input logic [1:0] p, input logic [1:0] m, input int rec);
    @(posedge Clk); #2; Plus = p; Minus = m; Vsync = 1'b1; Recenter = (rec == 1);
    @(posedge Clk); #2; Recenter = 1'b0;
    @(posedge Clk); #2; Vsync = 1'b0;
    @(posedge Clk); #2; Recenter = (rec == 2);
    @(posedge Clk); #2; Recenter = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
  endtask

  int t2[10] = '{1, 2, 3, 4, 6, 8, 10, 12, 16, 20};
  int t3[3]  = '{8'h81, 8'h82, 8'h83};
  logic [1:0] p_run, m_run;
  int len, rec;

  initial begin
    // Reset state
    repeat (3) @(posedge Clk);
    #2;
    chk("reset_value", int'(Value), 16'h0080);
    chk("reset_update", int'(Update), 0);
    chk("reset_active", int'(Active), 0);
    chk_en = 1'b1;
    Rst_n  = 1'b1;
    repeat (2) @(posedge Clk);

    // Acceleration on a holding channel
    for (int k = 0; k < 10; k++) begin
      frame(2'b10, 2'b00, 0);
      chk("accel_ch1", int'(Value[15:8]), t2[k]);
      chk("accel_model", m_val[1], t2[k]);
    end

    // Centering ramp, ch1 released and holding
    for (int k = 0; k < 3; k++) begin
      frame(2'b01, 2'b00, 0);
      chk("ramp_ch0", int'(Value[7:0]), t3[k]);
    end
    chk("hold_ch1", int'(Value[15:8]), 20);
    chk("hold_active1", int'(Active[1]), 0);
    frame(2'b00, 2'b00, 0);
    chk("release_ch0", int'(Value[7:0]), 8'h83);
    chk("return_active0", int'(Active[0]), 1);
    frame(2'b00, 2'b00, 0);
    chk("return_ch0", int'(Value[7:0]), 8'h80);
    chk("return_done", int'(Active[0]), 0);

    // Both buttons cancel; clamp at VMAX
    frame(2'b01, 2'b01, 0);
    chk("both_ch0", int'(Value[7:0]), 8'h80);
    for (int k = 0; k < 40; k++) frame(2'b10, 2'b00, 0);
    chk("clamp_ch1", int'(Value[15:8]), 8'hFF);
    chk("clamp_active", int'(Active), 2'b10);

    // Reverse after full acceleration, then Recenter on a tick
    frame(2'b00, 2'b10, 0);
    chk("reverse_ch1", int'(Value[15:8]), 8'hFE);
    frame(2'b10, 2'b00, 1);
    chk("recenter_value", int'(Value), 16'h0080);
    chk("recenter_active", int'(Active), 0);

    // Asynchronous reset mid-ramp
    for (int k = 0; k < 3; k++) frame(2'b10, 2'b00, 0);
    chk("preramp_ch1", int'(Value[15:8]), 3);
    @(posedge Clk);
    #3;
    Rst_n = 1'b0;
    #1;
    chk("async_value", int'(Value), 16'h0080);
    chk("async_active", int'(Active), 0);
    chk("async_update", int'(Update), 0);
    @(posedge Clk);
    #2;
    Rst_n = 1'b1;
    Plus  = 2'b00;

    // Randomized runs of button activity
    for (int r = 0; r < 60; r++) begin
      p_run = 2'($urandom);
      m_run = 2'($urandom);
      len   = int'($urandom_range(1, 14));
      for (int f = 0; f < len; f++) begin
        rec = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0;
        frame(p_run, m_run, rec);
      end
      if ($urandom_range(0, 2) == 0) begin
        frame(2'b00, 2'b00, 0);
        frame(2'b00, 2'b00, 0);
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
